fir_decim_serializer: RTL and testbench

//  Downstream stage of the FIR datapath: takes each 8-bit filtered sample with its valid strobe and keeps every DECIM-th one.

---
 rtl/fir_pkg.sv | 21 ++
 rtl/fir_sync_fifo.sv | 61 ++++++
 rtl/fir_decim_serializer.sv | 148 ++++++++++++++
 tb/tb_fir_decim_serializer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR decimating serializer: default sample width,
// serializer state encoding and a constant-evaluable clog2 helper.
package fir_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ser_state_e;

  // Ceiling log2 for sizing counters and pointers; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Synchronous FIFO with occupancy count; a push at full is accepted only when a
// pop happens in the same cycle, leaving the level unchanged.
module fir_sync_fifo
  import fir_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is deliberately not reset; level_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fir_decim_serializer.sv
// Keeps every DECIM-th valid FIR sample, buffers it and shifts it out MSB-first
// on a framed 3-wire link; drops on a full FIFO raise a sticky overflow flag.
module fir_decim_serializer
  import fir_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  input  logic                       ovf_clr,
  output logic                       ser_clk,
  output logic                       ser_data,
  output logic                       ser_frame,
  output logic                       busy,
  output logic                       ovf,
  output logic [clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int DCW  = 5;
  localparam int DIVW = clog2(2 * CLK_DIV) + 1;
  localparam int BITW = clog2(DATA_W) + 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(2 * CLK_DIV - 1);

  ser_state_e        state_q, state_d;
  logic [DCW-1:0]    decim_cnt_q, decim_cnt_d;
  logic [DIVW-1:0]   div_cnt_q, div_cnt_d;
  logic [BITW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              ovf_q, ovf_d;
  logic              ser_clk_q, ser_clk_d;
  logic              ser_data_q, ser_data_d;
  logic              ser_frame_q, ser_frame_d;

  logic              keep, drop, pop;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  fir_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (keep),
    .pop   (pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign keep = in_valid && (decim_cnt_q == '0);
  assign drop = keep && fifo_full && !pop;

  always_comb begin
    decim_cnt_d = decim_cnt_q;
    if (in_valid) begin
      decim_cnt_d = (decim_cnt_q == DCW'(DECIM - 1)) ? '0 : decim_cnt_q + 1'b1;
    end
    // A drop outranks a same-cycle clear so no overflow event is ever lost.
    ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shreg_d   = fifo_rdata;
          bit_cnt_d = BITW'(DATA_W - 1);
          div_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (bit_cnt_q == '0) begin
            state_d = GAP;
          end else begin
            shreg_d   = shreg_q << 1;
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Serial pins are derived from next state so they leave the flops glitch-free.
    ser_frame_d = (state_d == SHIFT);
    ser_clk_d   = (state_d == SHIFT) && (div_cnt_d >= DIVW'(CLK_DIV));
    ser_data_d  = (state_d == SHIFT) && shreg_d[DATA_W-1];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      decim_cnt_q <= '0;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      ovf_q       <= 1'b0;
      ser_clk_q   <= 1'b0;
      ser_data_q  <= 1'b0;
      ser_frame_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      decim_cnt_q <= decim_cnt_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      ovf_q       <= ovf_d;
      ser_clk_q   <= ser_clk_d;
      ser_data_q  <= ser_data_d;
      ser_frame_q <= ser_frame_d;
    end
  end

  assign ser_clk   = ser_clk_q;
  assign ser_data  = ser_data_q;
  assign ser_frame = ser_frame_q;
  assign ovf       = ovf_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_fir_decim_serializer.sv
// Directed bench: a DECIM=1 and a DECIM=4 instance; expected words are queued when
// stimulus is driven and compared as each serial word is received.
module tb_fir_decim_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a_data = '0, b_data = '0;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic       a_clr = 1'b0, b_clr = 1'b0;

  logic       sc [2];
  logic       sd [2];
  logic       sf [2];
  logic       busy_w [2];
  logic       ovf_w [2];
  logic [2:0] lvl_w [2];

  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_decim_serializer #(.DATA_W(8), .DECIM(1), .FIFO_DEPTH(4), .CLK_DIV(2)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .ovf_clr(a_clr),
    .ser_clk(sc[0]), .ser_data(sd[0]), .ser_frame(sf[0]),
    .busy(busy_w[0]), .ovf(ovf_w[0]), .fifo_level(lvl_w[0])
  );

  fir_decim_serializer #(.DATA_W(8), .DECIM(4), .FIFO_DEPTH(4), .CLK_DIV(2)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .ovf_clr(b_clr),
    .ser_clk(sc[1]), .ser_data(sd[1]), .ser_frame(sf[1]),
    .busy(busy_w[1]), .ovf(ovf_w[1]), .fifo_level(lvl_w[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_size(input int id);
    return (id == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [7:0] pop_exp(input int id);
    if (id == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  task automatic check_quiet(input int g, input string tag);
    check({tag, "_ser_clk"},   sc[g],     1'b0);
    check({tag, "_ser_data"},  sd[g],     1'b0);
    check({tag, "_ser_frame"}, sf[g],     1'b0);
    check({tag, "_busy"},      busy_w[g], 1'b0);
    check({tag, "_ovf"},       ovf_w[g],  1'b0);
    check({tag, "_level"},     lvl_w[g],  3'd0);
  endtask

  task automatic wait_frame(input int g, input logic lvl, input int budget, input string tag);
    int n = 0;
    while (sf[g] !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, sf[g], lvl);
  endtask

  task automatic wait_idle(input int g, input int budget, input string tag);
    int n = 0;
    while (busy_w[g] !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy_w[g], 1'b0);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_mon
    logic [7:0] word = '0;
    int         nbits = 0;
    int         flen = 0;
    logic       pf = 1'b0, pc = 1'b0, pd = 1'b0;

    always @(posedge sc[g] or posedge rst) begin
      if (rst) begin
        nbits = 0;
      end else if (sf[g]) begin
        word = {word[6:0], sd[g]};
        nbits++;
        if (nbits == 8) begin
          nbits = 0;
          check("word_expected", exp_size(g) > 0, 1'b1);
          if (exp_size(g) > 0) check("word_value", word, pop_exp(g));
        end
      end
    end

    always @(negedge clk) begin
      if (rst) begin
        flen = 0;
        pf = 1'b0;
        pc = 1'b0;
        pd = 1'b0;
      end else begin
        if (sf[g]) flen++;
        else if (pf) begin
          check("frame_len", flen, 32);
          flen = 0;
        end
        if (pc && sc[g]) check("data_stable_while_sclk_high", sd[g], pd);
        pf = sf[g];
        pc = sc[g];
        pd = sd[g];
      end
    end
  end

  initial begin
    int cycles;

    // Reset state
    repeat (2) @(negedge clk);
    check_quiet(0, "por_a");
    check_quiet(1, "por_b");
    #1 rst = 1'b0;

    // Single 0xA5 word: latency, frame length, gap then idle
    @(negedge clk);
    a_data = 8'hA5; a_valid = 1'b1; exp_q0.push_back(8'hA5);
    @(negedge clk);
    a_valid = 1'b0;
    check("lat_frame_low", sf[0], 1'b0);
    @(negedge clk);
    check("lat_frame_high", sf[0], 1'b1);
    wait_frame(0, 1'b0, 40, "a5_frame_end");
    cycles = 0;
    while (busy_w[0] === 1'b1 && cycles < 10) begin
      cycles++;
      @(negedge clk);
    end
    check("gap_busy_cycles", cycles, 4);

    // DECIM=4: only 0x00 and 0x04 survive
    for (int i = 0; i < 8; i++) begin
      b_data = 8'(i); b_valid = 1'b1;
      if (i % 4 == 0) exp_q1.push_back(8'(i));
      @(negedge clk);
      b_valid = 1'b0;
      repeat (39) @(negedge clk);
    end
    check("decim_ovf", ovf_w[1], 1'b0);
    check("decim_queue_drained", exp_q1.size(), 0);

    // Burst of six into a four-deep FIFO: last one dropped
    for (int i = 0; i < 6; i++) begin
      a_data = 8'h10 + 8'(i); a_valid = 1'b1;
      if (i < 5) exp_q0.push_back(8'h10 + 8'(i));
      if (i == 5) check("ovf_before_drop", ovf_w[0], 1'b0);
      @(negedge clk);
    end
    a_valid = 1'b0;
    check("ovf_after_drop", ovf_w[0], 1'b1);
    check("level_full", lvl_w[0], 3'd4);
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    check("ovf_cleared", ovf_w[0], 1'b0);

    // Push on the IDLE pop cycle with a full FIFO
    wait_frame(0, 1'b0, 40, "w10_frame_end");
    repeat (4) @(negedge clk);
    check("idle_level_full", lvl_w[0], 3'd4);
    a_data = 8'h16; a_valid = 1'b1; exp_q0.push_back(8'h16);
    @(negedge clk);
    a_valid = 1'b0;
    check("pushpop_level", lvl_w[0], 3'd4);
    check("pushpop_ovf", ovf_w[0], 1'b0);
    check("pushpop_frame", sf[0], 1'b1);

    // Drop coincident with ovf_clr: set wins
    a_data = 8'h17; a_valid = 1'b1; a_clr = 1'b1;
    @(negedge clk);
    a_valid = 1'b0; a_clr = 1'b0;
    check("drop_vs_clr_ovf", ovf_w[0], 1'b1);
    wait_idle(0, 300, "burst_drain");
    check("burst_queue_drained", exp_q0.size(), 0);
    check("ovf_sticky", ovf_w[0], 1'b1);

    // Reset during bit 3 of 0x3C, then a clean 0x81
    a_data = 8'h3C; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    wait_frame(0, 1'b1, 5, "w3c_frame_start");
    repeat (18) @(negedge clk);
    check("bit3_sclk_high", sc[0], 1'b1);
    check("bit3_data", sd[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    check_quiet(0, "async_rst_a");
    check_quiet(1, "async_rst_b");
    repeat (2) @(negedge clk);
    check_quiet(0, "held_rst_a");
    #1 rst = 1'b0;
    @(negedge clk);
    a_data = 8'h81; a_valid = 1'b1; exp_q0.push_back(8'h81);
    @(negedge clk);
    a_valid = 1'b0;
    wait_frame(0, 1'b1, 5, "w81_frame_start");
    wait_idle(0, 60, "w81_drain");
    wait_idle(1, 60, "b_drain");
    check("final_queue_a", exp_q0.size(), 0);
    check("final_queue_b", exp_q1.size(), 0);
    check("final_ovf_a", ovf_w[0], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
